eth_10gb_apb_master: RTL and testbench
======================================

// Module: eth_10gb_apb_master
// PURPOSE
//  APB initiator that drives the APB completer ports of the 10GbE MAC and PCS in eth_10gb_top.
//  Accepts one register command at a time from the control plane (valid/ready).
//  Runs a single APB write or read, or a read-poll loop, on the MAC or PCS port.
//  Returns rdata and a completion status.
//  Used for bring-up sequences such as waiting for PCS block lock and programming the MAC config.
// PARAMETERS
//  TIMEOUT_CYC   1024  max ACCESS cycles waiting for pready before abort (>=2)
//  POLL_MAX      16    max reads per poll command (1..255)
//  POLL_GAP_CYC  8     idle cycles between poll reads (>=0)
// PORTS
//  i_aclk              in   1   APB clock
//  i_arst_n            in   1   async active-low reset
//  i_cmd_valid         in   1   command valid
//  o_cmd_ready         out  1   command ready (1 only in IDLE)
//  i_cmd_target        in   1   0=MAC port, 1=PCS port
//  i_cmd_write         in   1   1=write, 0=read
//  i_cmd_poll          in   1   read-poll (ignored when i_cmd_write=1)
//  i_cmd_addr          in   32  register address
//  i_cmd_wdata         in   32  write data; for a poll, the expected value
//  i_cmd_mask          in   32  poll compare mask
//  o_rsp_valid         out  1   response valid
//  i_rsp_ready         in   1   response accept
//  o_rsp_rdata         out  32  last read data (0 for writes)
//  o_rsp_status        out  2   00 OK, 01 SLVERR, 10 TIMEOUT, 11 POLL_FAIL
//  o_rsp_reads         out  8   number of APB reads performed
//  o_busy              out  1   state != IDLE
//  o_mac_apb_psel/penable/pwrite  out 1; o_mac_apb_paddr/pwdata out 32
//  i_mac_apb_pready    in 1; i_mac_apb_prdata in 32; i_mac_apb_pserr in 1
//  o_pcs_apb_psel/penable/pwrite  out 1; o_pcs_apb_paddr/pwdata out 32
//  i_pcs_apb_pready    in 1; i_pcs_apb_prdata in 32 (only [15:0] used); i_pcs_apb_pserr in 1
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; every output 0 except o_cmd_ready=1; all counters 0.
//   - An APB transfer in flight is abandoned; no response is issued.
//  FSM states: IDLE, SETUP, ACCESS, GAP, RESP.
//  IDLE:
//   - On i_cmd_valid & o_cmd_ready, latch the command, clear the read count, go to SETUP.
//  SETUP (1 cycle):
//   - Selected target's psel=1, penable=0; paddr/pwdata/pwrite driven from the latched command.
//   - Next state: ACCESS.
//  ACCESS:
//   - psel=1, penable=1; paddr/pwdata/pwrite held stable.
//   - The timeout counter increments each cycle.
//   - pready=1:
//     - Reads capture prdata and increment the read count. PCS prdata[31:16] is forced to 0.
//     - pserr=1 -> status 01, go to RESP.
//     - Else, if poll and (rdata&mask)!=(wdata&mask):
//       - read count < POLL_MAX -> go to GAP (or to SETUP when POLL_GAP_CYC=0).
//       - otherwise -> status 11, go to RESP.
//     - Otherwise -> status 00, go to RESP.
//   - Counter reaches TIMEOUT_CYC with pready=0 -> deassert psel/penable, status 10, go to RESP.
//  GAP:
//   - psel=0; count POLL_GAP_CYC cycles, then go to SETUP. The timeout counter is cleared on entry to SETUP.
//  RESP:
//   - o_rsp_valid=1; rdata/status/reads held stable until i_rsp_ready.
//   - Handshake cycle -> IDLE; o_rsp_valid is low the next cycle.
//  Bus rules:
//   - Outside SETUP/ACCESS, all APB outputs are 0.
//   - Only the selected target's psel is asserted; the unselected port is held at 0.
//  Latency: command accepted at cycle 0, SETUP at 1, ACCESS at 2; pready in the same cycle -> o_rsp_valid at 3.
//  Command handling:
//   - No command queuing: a new command is accepted only in IDLE.
//   - A poll with mask=0 completes OK after 1 read.
//  Write responses: o_rsp_rdata=0, o_rsp_reads=0.
// TESTING
//  1 MAC write addr=0x10 data=0xA5A5_0001, pready at first ACCESS cycle
//    -> psel 2 cycles, penable 1 cycle; rsp at cycle 3 with status 00, rdata 0.
//  2 PCS read addr=0x0020, prdata=0xDEAD_1234
//    -> rsp rdata=0x0000_1234, status 00, reads=1; MAC psel stays 0 throughout.
//  3 PCS poll mask=0x1 wdata=0x1; prdata bit0 goes high on the 3rd read
//    -> status 00, reads=3, exactly 8 idle cycles between reads.
//  4 Poll with bit never set, POLL_MAX=16 -> status 11, reads=16.
//  5 MAC read with pready stuck low -> after 1024 ACCESS cycles, psel drops and status=10.
//    MAC pserr=1 on a write -> status=01.
//  6 Assert i_arst_n low mid-ACCESS of a poll
//    -> all APB outputs 0 immediately; no rsp issued; after release a new command is accepted and completes OK.
//    Also hold i_rsp_ready=0 for 5 cycles -> response stable, o_cmd_ready stays 0.

Source files
------------

// File: rtl/eth_10gb_apb_master_if.sv
// rtl/eth_10gb_apb_master_if.sv - command/response and MAC/PCS APB signal bundle for eth_10gb_apb_master
interface eth_10gb_apb_master_if;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_target;
    logic        i_cmd_write;
    logic        i_cmd_poll;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic [31:0] i_cmd_mask;

    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_status;
    logic [7:0]  o_rsp_reads;
    logic        o_busy;

    logic        o_mac_apb_psel;
    logic        o_mac_apb_penable;
    logic        o_mac_apb_pwrite;
    logic [31:0] o_mac_apb_paddr;
    logic [31:0] o_mac_apb_pwdata;
    logic        i_mac_apb_pready;
    logic [31:0] i_mac_apb_prdata;
    logic        i_mac_apb_pserr;

    logic        o_pcs_apb_psel;
    logic        o_pcs_apb_penable;
    logic        o_pcs_apb_pwrite;
    logic [31:0] o_pcs_apb_paddr;
    logic [31:0] o_pcs_apb_pwdata;
    logic        i_pcs_apb_pready;
    logic [31:0] i_pcs_apb_prdata;
    logic        i_pcs_apb_pserr;

    modport master (
        input  i_cmd_valid, i_cmd_target, i_cmd_write, i_cmd_poll,
        input  i_cmd_addr, i_cmd_wdata, i_cmd_mask, i_rsp_ready,
        output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_status, o_rsp_reads, o_busy,
        output o_mac_apb_psel, o_mac_apb_penable, o_mac_apb_pwrite, o_mac_apb_paddr, o_mac_apb_pwdata,
        input  i_mac_apb_pready, i_mac_apb_prdata, i_mac_apb_pserr,
        output o_pcs_apb_psel, o_pcs_apb_penable, o_pcs_apb_pwrite, o_pcs_apb_paddr, o_pcs_apb_pwdata,
        input  i_pcs_apb_pready, i_pcs_apb_prdata, i_pcs_apb_pserr
    );

    modport slave (
        output i_cmd_valid, i_cmd_target, i_cmd_write, i_cmd_poll,
        output i_cmd_addr, i_cmd_wdata, i_cmd_mask, i_rsp_ready,
        input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_status, o_rsp_reads, o_busy,
        input  o_mac_apb_psel, o_mac_apb_penable, o_mac_apb_pwrite, o_mac_apb_paddr, o_mac_apb_pwdata,
        output i_mac_apb_pready, i_mac_apb_prdata, i_mac_apb_pserr,
        input  o_pcs_apb_psel, o_pcs_apb_penable, o_pcs_apb_pwrite, o_pcs_apb_paddr, o_pcs_apb_pwdata,
        output i_pcs_apb_pready, i_pcs_apb_prdata, i_pcs_apb_pserr
    );
endinterface

// File: rtl/eth_10gb_apb_master.sv
// rtl/eth_10gb_apb_master.sv - APB initiator running single writes/reads or read-poll loops on the MAC or PCS port
module eth_10gb_apb_master #(
    parameter int TIMEOUT_CYC  = 1024,
    parameter int POLL_MAX     = 16,
    parameter int POLL_GAP_CYC = 8
) (
    input  logic                  i_aclk,
    input  logic                  i_arst_n,
    eth_10gb_apb_master_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_GAP, S_RESP} state_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = (POLL_GAP_CYC > 1) ? $clog2(POLL_GAP_CYC) : 1;

    state_t         state, state_nx;
    logic           tgt_q, wr_q, poll_q;
    logic [31:0]    addr_q, wdata_q, mask_q, rdata_q;
    logic [1:0]     status_q;
    logic [7:0]     reads_q;
    logic [TW-1:0]  tmo_q;
    logic [GW-1:0]  gap_q;

    logic           pready_sel, pserr_sel, poll_miss, reads_more, tmo_hit, gap_done;
    logic [31:0]    prdata_sel;
    logic [7:0]     reads_inc;
    logic           pcs_prdata_unused;

    // PCS registers are 16 bits wide; the upper half of its prdata is never trusted.
    assign pready_sel = tgt_q ? bus.i_pcs_apb_pready : bus.i_mac_apb_pready;
    assign pserr_sel  = tgt_q ? bus.i_pcs_apb_pserr  : bus.i_mac_apb_pserr;
    assign prdata_sel = tgt_q ? {16'h0000, bus.i_pcs_apb_prdata[15:0]} : bus.i_mac_apb_prdata;
    assign pcs_prdata_unused = ^bus.i_pcs_apb_prdata[31:16];

    assign reads_inc  = reads_q + 8'd1;
    assign poll_miss  = poll_q && ((prdata_sel & mask_q) != (wdata_q & mask_q));
    assign reads_more = (32'(reads_inc) < 32'(POLL_MAX));
    assign tmo_hit    = (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign gap_done   = (gap_q == GW'(POLL_GAP_CYC - 1));

    always_ff @(posedge i_aclk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (bus.i_cmd_valid) state_nx = S_SETUP;
            S_SETUP:  state_nx = S_ACCESS;
            S_ACCESS: begin
                if (pready_sel) begin
                    if (!pserr_sel && poll_miss && reads_more)
                        state_nx = (POLL_GAP_CYC == 0) ? S_SETUP : S_GAP;
                    else
                        state_nx = S_RESP;
                end else if (tmo_hit) begin
                    state_nx = S_RESP;
                end
            end
            S_GAP:    if (gap_done) state_nx = S_SETUP;
            S_RESP:   if (bus.i_rsp_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            tgt_q    <= 1'b0;
            wr_q     <= 1'b0;
            poll_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            rdata_q  <= '0;
            status_q <= 2'b00;
            reads_q  <= '0;
            tmo_q    <= '0;
            gap_q    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.i_cmd_valid) begin
                        tgt_q    <= bus.i_cmd_target;
                        wr_q     <= bus.i_cmd_write;
                        poll_q   <= bus.i_cmd_poll & ~bus.i_cmd_write;
                        addr_q   <= bus.i_cmd_addr;
                        wdata_q  <= bus.i_cmd_wdata;
                        mask_q   <= bus.i_cmd_mask;
                        rdata_q  <= '0;
                        status_q <= 2'b00;
                        reads_q  <= '0;
                    end
                end
                S_SETUP: begin
                    tmo_q <= '0;
                end
                S_ACCESS: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (pready_sel) begin
                        gap_q <= '0;
                        if (!wr_q) begin
                            rdata_q <= prdata_sel;
                            reads_q <= reads_inc;
                        end
                        if (pserr_sel)
                            status_q <= 2'b01;
                        else if (poll_miss && !reads_more)
                            status_q <= 2'b11;
                        else
                            status_q <= 2'b00;
                    end else if (tmo_hit) begin
                        status_q <= 2'b10;
                    end
                end
                S_GAP: begin
                    gap_q <= gap_q + GW'(1);
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decode straight from state so an async reset zeroes them without a clock.
    always_comb begin
        bus.o_cmd_ready       = (state == S_IDLE);
        bus.o_busy            = (state != S_IDLE);
        bus.o_rsp_valid       = (state == S_RESP);
        bus.o_rsp_rdata       = (state == S_RESP) ? rdata_q  : 32'h0;
        bus.o_rsp_status      = (state == S_RESP) ? status_q : 2'b00;
        bus.o_rsp_reads       = (state == S_RESP) ? reads_q  : 8'h00;

        bus.o_mac_apb_psel    = 1'b0;
        bus.o_mac_apb_penable = 1'b0;
        bus.o_mac_apb_pwrite  = 1'b0;
        bus.o_mac_apb_paddr   = 32'h0;
        bus.o_mac_apb_pwdata  = 32'h0;
        bus.o_pcs_apb_psel    = 1'b0;
        bus.o_pcs_apb_penable = 1'b0;
        bus.o_pcs_apb_pwrite  = 1'b0;
        bus.o_pcs_apb_paddr   = 32'h0;
        bus.o_pcs_apb_pwdata  = 32'h0;

        if (state == S_SETUP || state == S_ACCESS) begin
            if (tgt_q) begin
                bus.o_pcs_apb_psel    = 1'b1;
                bus.o_pcs_apb_penable = (state == S_ACCESS);
                bus.o_pcs_apb_pwrite  = wr_q;
                bus.o_pcs_apb_paddr   = addr_q;
                bus.o_pcs_apb_pwdata  = wdata_q;
            end else begin
                bus.o_mac_apb_psel    = 1'b1;
                bus.o_mac_apb_penable = (state == S_ACCESS);
                bus.o_mac_apb_pwrite  = wr_q;
                bus.o_mac_apb_paddr   = addr_q;
                bus.o_mac_apb_pwdata  = wdata_q;
            end
        end
    end
endmodule

// File: tb/tb_eth_10gb_apb_master.sv
// tb/tb_eth_10gb_apb_master.sv - self-checking bench for eth_10gb_apb_master
module tb_eth_10gb_apb_master;
    localparam int TMO  = 1024;
    localparam int PMAX = 16;
    localparam int GAPC = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_10gb_apb_master_if bus();

    eth_10gb_apb_master #(.TIMEOUT_CYC(TMO), .POLL_MAX(PMAX), .POLL_GAP_CYC(GAPC)) dut (
        .i_aclk   (clk),
        .i_arst_n (rst_n),
        .bus      (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Behavioural APB completer shared by both ports, plus a bus monitor.
    int          slv_wait = 0;
    bit          slv_err  = 1'b0;
    bit          slv_clr  = 1'b0;
    logic [31:0] slv_data [0:31];
    int          acc_cnt = 0, xfer_idx = 0;
    int          mac_sel_cyc = 0, pcs_sel_cyc = 0, pen_cyc = 0;
    int          gap_run = 0, gap_min = 0, gap_max = 0, viol = 0;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic        exp_write = 1'b0;

    logic        sel_any, en_any, slv_rdy;
    logic [31:0] cur_data, paddr_sel, pwdata_sel;
    logic        pwrite_sel;

    assign sel_any    = bus.o_mac_apb_psel | bus.o_pcs_apb_psel;
    assign en_any     = bus.o_mac_apb_penable | bus.o_pcs_apb_penable;
    assign slv_rdy    = (acc_cnt >= slv_wait);
    assign cur_data   = (xfer_idx < 32) ? slv_data[xfer_idx[4:0]] : 32'h0;
    assign paddr_sel  = bus.o_mac_apb_psel ? bus.o_mac_apb_paddr  : bus.o_pcs_apb_paddr;
    assign pwdata_sel = bus.o_mac_apb_psel ? bus.o_mac_apb_pwdata : bus.o_pcs_apb_pwdata;
    assign pwrite_sel = bus.o_mac_apb_psel ? bus.o_mac_apb_pwrite : bus.o_pcs_apb_pwrite;

    assign bus.i_mac_apb_pready = slv_rdy & bus.o_mac_apb_psel;
    assign bus.i_pcs_apb_pready = slv_rdy & bus.o_pcs_apb_psel;
    assign bus.i_mac_apb_prdata = cur_data;
    assign bus.i_pcs_apb_prdata = cur_data;
    assign bus.i_mac_apb_pserr  = slv_err & bus.o_mac_apb_psel;
    assign bus.i_pcs_apb_pserr  = slv_err & bus.o_pcs_apb_psel;

    always @(posedge clk) begin
        if (slv_clr) begin
            acc_cnt <= 0; xfer_idx <= 0;
            mac_sel_cyc <= 0; pcs_sel_cyc <= 0; pen_cyc <= 0;
            gap_run <= 0; gap_min <= 1 << 30; gap_max <= 0; viol <= 0;
        end else begin
            if (sel_any && en_any) begin
                if (slv_rdy) begin acc_cnt <= 0; xfer_idx <= xfer_idx + 1; end
                else acc_cnt <= acc_cnt + 1;
            end
            if (bus.o_mac_apb_psel) mac_sel_cyc <= mac_sel_cyc + 1;
            if (bus.o_pcs_apb_psel) pcs_sel_cyc <= pcs_sel_cyc + 1;
            if (en_any) pen_cyc <= pen_cyc + 1;
            if (bus.o_busy && !sel_any && !bus.o_rsp_valid) begin
                gap_run <= gap_run + 1;
            end else if (sel_any && gap_run > 0) begin
                if (gap_run < gap_min) gap_min <= gap_run;
                if (gap_run > gap_max) gap_max <= gap_run;
                gap_run <= 0;
            end
            if (bus.o_mac_apb_psel && bus.o_pcs_apb_psel) viol <= viol + 1;
            else if ((bus.o_mac_apb_penable && !bus.o_mac_apb_psel) || (bus.o_pcs_apb_penable && !bus.o_pcs_apb_psel)) viol <= viol + 1;
            else if (sel_any && (paddr_sel != exp_addr || pwdata_sel != exp_wdata || pwrite_sel != exp_write)) viol <= viol + 1;
            else if (!sel_any && (|{bus.o_mac_apb_pwrite, bus.o_mac_apb_paddr, bus.o_mac_apb_pwdata,
                                    bus.o_pcs_apb_pwrite, bus.o_pcs_apb_paddr, bus.o_pcs_apb_pwdata})) viol <= viol + 1;
        end
    end

    // Reference: walks the completer's read-data list by the command rules.
    function automatic void model(input bit wr, input bit poll, input bit pcs, input bit err,
                                  input logic [31:0] wdata, input logic [31:0] mask,
                                  output logic [31:0] r, output logic [1:0] st, output logic [7:0] rd);
        logic [31:0] d;
        r = '0; rd = '0; st = 2'b00;
        if (wr) begin
            st = err ? 2'b01 : 2'b00;
            return;
        end
        for (int i = 0; i < PMAX; i++) begin
            d  = pcs ? {16'h0, slv_data[i][15:0]} : slv_data[i];
            r  = d;
            rd = 8'(i + 1);
            if (err) begin st = 2'b01; return; end
            if (!poll || ((d & mask) == (wdata & mask))) begin st = 2'b00; return; end
        end
        st = 2'b11;
    endfunction

    task automatic run_cmd(input string tag, input bit tgt, input bit wr, input bit poll,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mask,
                           input int hold, input logic [31:0] er, input logic [1:0] est,
                           input logic [7:0] erd, output int lat);
        @(negedge clk);
        exp_addr = addr; exp_wdata = wdata; exp_write = wr;
        bus.i_cmd_valid = 1'b1; bus.i_cmd_target = tgt; bus.i_cmd_write = wr; bus.i_cmd_poll = poll;
        bus.i_cmd_addr = addr; bus.i_cmd_wdata = wdata; bus.i_cmd_mask = mask;
        slv_clr = 1'b1;
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
        slv_clr = 1'b0;
        lat = 1;
        while (!bus.o_rsp_valid && lat < 4000) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_rsp_valid"}, bus.o_rsp_valid, 1);
        chk({tag, "_rdata"},  bus.o_rsp_rdata,  er);
        chk({tag, "_status"}, bus.o_rsp_status, est);
        chk({tag, "_reads"},  bus.o_rsp_reads,  erd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {bus.o_rsp_valid, bus.o_cmd_ready}, 2'b10);
            chk({tag, "_hold_rsp"}, {bus.o_rsp_rdata, bus.o_rsp_status, bus.o_rsp_reads}, {er, est, erd});
        end
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        chk({tag, "_after_hs"}, {bus.o_rsp_valid, bus.o_cmd_ready}, 2'b01);
    endtask

    logic [31:0] er, addr, wdata, mask;
    logic [1:0]  est;
    logic [7:0]  erd;
    int          lat, k, w, m, n;
    bit          tgt, wr, poll, err;

    initial begin
        bus.i_cmd_valid = 1'b0; bus.i_cmd_target = 1'b0; bus.i_cmd_write = 1'b0; bus.i_cmd_poll = 1'b0;
        bus.i_cmd_addr = '0; bus.i_cmd_wdata = '0; bus.i_cmd_mask = '0; bus.i_rsp_ready = 1'b0;
        for (int i = 0; i < 32; i++) slv_data[i] = '0;

        repeat (3) @(negedge clk);
        chk("reset_ctl", {bus.o_cmd_ready, bus.o_rsp_valid, bus.o_busy}, 3'b100);
        chk("reset_apb", {sel_any, en_any, |bus.o_mac_apb_paddr, |bus.o_pcs_apb_paddr}, 0);
        rst_n = 1'b1;

        // MAC write, zero wait states
        model(1, 0, 0, 0, 32'hA5A5_0001, 0, er, est, erd);
        run_cmd("mac_wr", 0, 1, 0, 32'h10, 32'hA5A5_0001, 0, 0, er, est, erd, lat);
        chk("mac_wr_lat", lat, 3);
        chk("mac_wr_sel", {mac_sel_cyc, pcs_sel_cyc, pen_cyc, viol}, {32'd2, 32'd0, 32'd1, 32'd0});

        // PCS read; upper prdata half must be dropped
        slv_data[0] = 32'hDEAD_1234;
        run_cmd("pcs_rd", 1, 0, 0, 32'h20, 32'h0, 0, 0, 32'h0000_1234, 2'b00, 8'd1, lat);
        chk("pcs_rd_sel", {mac_sel_cyc, pcs_sel_cyc, viol}, {32'd0, 32'd2, 32'd0});

        // PCS poll on bit0, matching on the third read; five cycles of response back-pressure
        for (int i = 0; i < 32; i++) slv_data[i] = $urandom & 32'hFFFF_FFFE;
        slv_data[2] = slv_data[2] | 32'h1;
        model(0, 1, 1, 0, 32'h1, 32'h1, er, est, erd);
        run_cmd("pcs_poll", 1, 0, 1, 32'h44, 32'h1, 32'h1, 5, er, est, erd, lat);
        chk("pcs_poll_lat", lat, 1 + 3 * 2 + 2 * GAPC);
        chk("pcs_poll_gap", {gap_min, gap_max, viol}, {GAPC, GAPC, 32'd0});

        // Poll that never matches
        for (int i = 0; i < 32; i++) slv_data[i] = $urandom & 32'hFFFF_FFFE;
        model(0, 1, 0, 0, 32'h1, 32'h1, er, est, erd);
        run_cmd("poll_fail", 0, 0, 1, 32'h48, 32'h1, 32'h1, 0, er, est, erd, lat);
        chk("poll_fail_lat", lat, 1 + PMAX * 2 + (PMAX - 1) * GAPC);
        chk("poll_fail_xfers", {mac_sel_cyc, pen_cyc}, {32'(2 * PMAX), 32'(PMAX)});

        // MAC read with pready stuck low
        slv_wait = 100000;
        run_cmd("tmo", 0, 0, 0, 32'h80, 32'h0, 0, 0, 32'h0, 2'b10, 8'd0, lat);
        chk("tmo_lat", lat, TMO + 2);
        chk("tmo_cycles", {mac_sel_cyc, pen_cyc}, {32'(TMO + 1), 32'(TMO)});
        slv_wait = 0;

        // MAC write with slave error
        slv_err = 1'b1;
        run_cmd("serr_wr", 0, 1, 0, 32'h84, 32'h1234_5678, 0, 0, 32'h0, 2'b01, 8'd0, lat);
        slv_err = 1'b0;

        // Randomized commands
        for (int it = 0; it < 12; it++) begin
            tgt  = 1'($urandom_range(0, 1));
            wr   = ($urandom_range(0, 3) == 0);
            poll = !wr && ($urandom_range(0, 1) == 1);
            err  = ($urandom_range(0, 7) == 0);
            w    = $urandom_range(0, 3);
            addr = $urandom; wdata = $urandom;
            mask = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom & (tgt ? 32'h0000_FFFF : 32'hFFFF_FFFF));
            m    = $urandom_range(0, PMAX);
            for (int i = 0; i < 32; i++)
                slv_data[i] = (i >= m) ? ((wdata & mask) | ($urandom & ~mask)) : $urandom;
            slv_wait = w; slv_err = err;
            model(wr, poll, tgt, err, wdata, mask, er, est, erd);
            n = wr ? 1 : int'(erd);
            run_cmd("rand", tgt, wr, poll, addr, wdata, mask, $urandom_range(0, 3), er, est, erd, lat);
            chk("rand_lat", lat, 1 + n * (2 + w) + (n - 1) * GAPC);
            chk("rand_bus", viol, 0);
        end
        slv_wait = 0; slv_err = 1'b0;

        // Async reset in the middle of a poll ACCESS phase
        for (int i = 0; i < 32; i++) slv_data[i] = '0;
        slv_wait = 5;
        @(negedge clk);
        exp_addr = 32'h30; exp_wdata = 32'h1; exp_write = 1'b0;
        bus.i_cmd_valid = 1'b1; bus.i_cmd_target = 1'b1; bus.i_cmd_write = 1'b0; bus.i_cmd_poll = 1'b1;
        bus.i_cmd_addr = 32'h30; bus.i_cmd_wdata = 32'h1; bus.i_cmd_mask = 32'h1;
        slv_clr = 1'b1;
        @(negedge clk);
        bus.i_cmd_valid = 1'b0; slv_clr = 1'b0;
        k = 0;
        while (!bus.o_pcs_apb_penable && k < 100) begin @(negedge clk); k++; end
        chk("rst_in_access", bus.o_pcs_apb_penable, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_apb_zero", {sel_any, en_any, bus.o_pcs_apb_pwrite, |bus.o_pcs_apb_paddr, |bus.o_pcs_apb_pwdata,
                             bus.o_mac_apb_pwrite, |bus.o_mac_apb_paddr, |bus.o_mac_apb_pwdata}, 0);
        chk("rst_ctl", {bus.o_cmd_ready, bus.o_rsp_valid, bus.o_busy}, 3'b100);
        k = 0;
        repeat (3) begin @(negedge clk); if (bus.o_rsp_valid) k++; end
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); if (bus.o_rsp_valid) k++; end
        chk("rst_no_rsp", k, 0);
        slv_wait = 0;
        run_cmd("post_rst", 0, 1, 0, 32'h10, 32'h0000_00C3, 0, 0, 32'h0, 2'b00, 8'd0, lat);
        chk("post_rst_lat", lat, 3);

        // Poll with zero mask completes after one read
        for (int i = 0; i < 32; i++) slv_data[i] = $urandom;
        run_cmd("mask0", 0, 0, 1, 32'h90, 32'hFFFF_FFFF, 32'h0, 0, slv_data[0], 2'b00, 8'd1, lat);
        chk("mask0_lat", lat, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
